// File: rtl/jailbreak_hs_sequencer_pkg.sv
// rtl/jailbreak_hs_sequencer_pkg.sv - shared types and widths for the hi-score sequencer
package jailbreak_hs_sequencer_pkg;

    // Address width shared with the hi-score block and the dataslot staging buffer
    localparam int HS_ADDR_WIDTH = 12;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        HALT_WAIT    = 3'd1,
        LOAD_FETCH   = 3'd2,
        LOAD_WRITE   = 3'd3,
        SAVE_ADDR    = 3'd4,
        SAVE_CAPTURE = 3'd5,
        RELEASE      = 3'd6,
        DONE         = 3'd7
    } hs_seq_state_e;

endpackage

// File: rtl/jailbreak_hs_sequencer.sv
// rtl/jailbreak_hs_sequencer.sv - halts the core and copies hi-score bytes between core RAM and staging buffer
module jailbreak_hs_sequencer
    import jailbreak_hs_sequencer_pkg::*;
#(
    parameter int HS_BYTES     = 256,
    parameter int HALT_SETTLE  = 16,
    parameter int READ_LATENCY = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start_load,
    input  logic                     start_save,
    output logic                     busy,
    output logic                     done,
    output logic                     processor_halt,
    output logic [HS_ADDR_WIDTH-1:0] hs_address,
    output logic                     hs_access_write,
    output logic                     hs_write_enable,
    output logic [7:0]               hs_data_in,
    input  logic [7:0]               hs_data_out,
    output logic [HS_ADDR_WIDTH-1:0] buf_addr,
    output logic                     buf_wr,
    output logic [7:0]               buf_wr_data,
    input  logic [7:0]               buf_rd_data
);

    localparam int WAIT_MAX = (HALT_SETTLE > READ_LATENCY) ? HALT_SETTLE : READ_LATENCY;
    localparam int CNT_W    = $clog2(WAIT_MAX + 1);

    localparam logic [CNT_W-1:0]         SETTLE_RELOAD = CNT_W'(HALT_SETTLE - 1);
    localparam logic [CNT_W-1:0]         READ_RELOAD   = CNT_W'(READ_LATENCY - 1);
    localparam logic [HS_ADDR_WIDTH-1:0] LAST_IDX      = HS_ADDR_WIDTH'(HS_BYTES - 1);

    hs_seq_state_e              state_q, state_d;
    logic [HS_ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic                       is_load_q, is_load_d;
    logic [HS_ADDR_WIDTH-1:0]   hs_address_q;
    logic [HS_ADDR_WIDTH-1:0]   buf_addr_q;
    logic                       hs_addr_upd;
    logic                       buf_addr_upd;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            is_load_q    <= 1'b0;
            hs_address_q <= '0;
            buf_addr_q   <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            is_load_q <= is_load_d;
            if (hs_addr_upd) begin
                hs_address_q <= idx_d;
            end
            if (buf_addr_upd) begin
                buf_addr_q <= idx_d;
            end
        end
    end

    // One down-counter times both the halt settle and the RAM read latency
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        is_load_d = is_load_q;
        unique case (state_q)
            IDLE: begin
                if (start_load || start_save) begin
                    state_d   = HALT_WAIT;
                    is_load_d = start_load;
                    cnt_d     = SETTLE_RELOAD;
                end
            end
            HALT_WAIT: begin
                if (cnt_q == '0) begin
                    idx_d   = '0;
                    cnt_d   = READ_RELOAD;
                    state_d = is_load_q ? LOAD_FETCH : SAVE_ADDR;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            LOAD_FETCH: begin
                state_d = LOAD_WRITE;
            end
            LOAD_WRITE: begin
                if (idx_q == LAST_IDX) begin
                    state_d = RELEASE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = LOAD_FETCH;
                end
            end
            SAVE_ADDR: begin
                if (cnt_q == '0) begin
                    state_d = SAVE_CAPTURE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            SAVE_CAPTURE: begin
                if (idx_q == LAST_IDX) begin
                    state_d = RELEASE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    cnt_d   = READ_RELOAD;
                    state_d = SAVE_ADDR;
                end
            end
            RELEASE: begin
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Addresses are registered so they are valid from the first cycle of each access state
    always_comb begin
        hs_addr_upd  = (state_d == LOAD_WRITE) || (state_d == SAVE_ADDR) ||
                       (state_d == SAVE_CAPTURE);
        buf_addr_upd = (state_d == LOAD_FETCH) || (state_d == SAVE_CAPTURE);
    end

    assign busy            = (state_q != IDLE);
    assign done            = (state_q == DONE);
    assign processor_halt  = (state_q != IDLE) && (state_q != DONE);
    assign hs_access_write = is_load_q && ((state_q == HALT_WAIT) ||
                             (state_q == LOAD_FETCH) || (state_q == LOAD_WRITE));
    assign hs_write_enable = (state_q == LOAD_WRITE);
    assign hs_data_in      = (state_q == LOAD_WRITE) ? buf_rd_data : 8'h00;
    assign buf_wr          = (state_q == SAVE_CAPTURE);
    assign buf_wr_data     = (state_q == SAVE_CAPTURE) ? hs_data_out : 8'h00;
    assign hs_address      = hs_address_q;
    assign buf_addr        = buf_addr_q;

endmodule

// File: tb/tb_jailbreak_hs_sequencer.sv
// tb/tb_jailbreak_hs_sequencer.sv - directed self-checking bench for the hi-score sequencer
module tb_jailbreak_hs_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_load = 1'b0, start_save = 1'b0;
    logic        busy, done, processor_halt, hs_access_write, hs_write_enable, buf_wr;
    logic [11:0] hs_address, buf_addr;
    logic [7:0]  hs_data_in, hs_data_out, buf_wr_data, buf_rd_data;

    logic        start_load2 = 1'b0, start_save2 = 1'b0;
    logic        busy2, done2, halt2, aw2, we2, bwr2;
    logic [11:0] hs_address2, buf_addr2;
    logic [7:0]  hs_data_in2, hs_data_out2, buf_wr_data2;
    logic [7:0]  buf_rd_data2 = 8'h00;

    logic [7:0]  bmem [0:15];
    logic [7:0]  ram  [0:15];
    logic [7:0]  ram_d1, ram2_d1;

    int checks = 0;
    int errors = 0;

    bit          lg_halt [64], lg_busy [64], lg_done [64], lg_we [64], lg_bwr [64], lg_aw [64];
    bit          lg_bwr2 [64], lg_done2 [64];
    logic [11:0] lg_addr [64], lg_baddr [64], lg_baddr2 [64];
    logic [7:0]  lg_din [64], lg_bdata [64], lg_bdata2 [64];

    always #5 clk = ~clk;

    jailbreak_hs_sequencer #(.HS_BYTES(4), .HALT_SETTLE(2), .READ_LATENCY(2)) dut (
        .clk(clk), .reset(reset), .start_load(start_load), .start_save(start_save),
        .busy(busy), .done(done), .processor_halt(processor_halt),
        .hs_address(hs_address), .hs_access_write(hs_access_write),
        .hs_write_enable(hs_write_enable), .hs_data_in(hs_data_in), .hs_data_out(hs_data_out),
        .buf_addr(buf_addr), .buf_wr(buf_wr), .buf_wr_data(buf_wr_data), .buf_rd_data(buf_rd_data)
    );

    jailbreak_hs_sequencer #(.HS_BYTES(1), .HALT_SETTLE(1), .READ_LATENCY(2)) dut_one (
        .clk(clk), .reset(reset), .start_load(start_load2), .start_save(start_save2),
        .busy(busy2), .done(done2), .processor_halt(halt2),
        .hs_address(hs_address2), .hs_access_write(aw2),
        .hs_write_enable(we2), .hs_data_in(hs_data_in2), .hs_data_out(hs_data_out2),
        .buf_addr(buf_addr2), .buf_wr(bwr2), .buf_wr_data(buf_wr_data2), .buf_rd_data(buf_rd_data2)
    );

    // Staging buffer: 1-cycle read; core RAM: 2-cycle read
    always @(posedge clk) begin
        buf_rd_data <= bmem[buf_addr[3:0]];
        if (buf_wr) bmem[buf_addr[3:0]] <= buf_wr_data;
        ram_d1      <= ram[hs_address[3:0]];
        hs_data_out <= ram_d1;
        if (hs_write_enable) ram[hs_address[3:0]] <= hs_data_in;
        ram2_d1      <= (hs_address2 == 12'd0) ? 8'h5A : 8'hFF;
        hs_data_out2 <= ram2_d1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run(input int n, input int ld_at, input int sv_at, input int rst_at,
                       input int sv2_at);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            lg_halt[c]  = processor_halt; lg_busy[c] = busy; lg_done[c] = done;
            lg_we[c]    = hs_write_enable; lg_bwr[c] = buf_wr; lg_aw[c] = hs_access_write;
            lg_addr[c]  = hs_address; lg_baddr[c] = buf_addr;
            lg_din[c]   = hs_data_in; lg_bdata[c] = buf_wr_data;
            lg_bwr2[c]  = bwr2; lg_done2[c] = done2;
            lg_baddr2[c] = buf_addr2; lg_bdata2[c] = buf_wr_data2;
            start_load  = (c == ld_at);
            start_save  = (c == sv_at);
            reset       = (c == rst_at);
            start_save2 = (c == sv2_at);
        end
        @(negedge clk);
        start_load = 1'b0; start_save = 1'b0; reset = 1'b0; start_save2 = 1'b0;
    endtask

    task automatic preload(input logic [31:0] bwords, input logic [31:0] rwords);
        for (int i = 0; i < 16; i++) begin
            bmem[i] <= (i < 4) ? bwords[31-8*i -: 8] : 8'h00;
            ram[i]  <= (i < 4) ? rwords[31-8*i -: 8] : 8'h00;
        end
        @(negedge clk);
    endtask

    int n_done, n_bwr, n_we, n_both;

    task automatic count_pulses(input int n);
        n_done = 0; n_bwr = 0; n_we = 0; n_both = 0;
        for (int c = 0; c < n; c++) begin
            n_done += int'(lg_done[c]);
            n_bwr  += int'(lg_bwr[c]);
            n_we   += int'(lg_we[c]);
            n_both += int'(lg_we[c] && lg_bwr[c]);
        end
    endtask

    initial begin
        logic [31:0] exp_b;
        preload(32'h11223344, 32'hA0A1A2A3);
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_halt", processor_halt, 0);
        check("rst_addr", {hs_address, buf_addr}, 0);
        check("rst_strobes", {done, hs_access_write, hs_write_enable, buf_wr}, 0);
        reset = 1'b0;
        @(negedge clk);

        // Load of 4 bytes
        run(20, 0, -1, -1, -1);
        exp_b = 32'h11223344;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("ld_we%0d", k), lg_we[4+2*k], 1);
            check($sformatf("ld_addr%0d", k), lg_addr[4+2*k], k);
            check($sformatf("ld_data%0d", k), lg_din[4+2*k], exp_b[31-8*k -: 8]);
            check($sformatf("ld_gap%0d", k), lg_we[5+2*k], 0);
            check($sformatf("ld_ram%0d", k), ram[k], exp_b[31-8*k -: 8]);
        end
        check("ld_halt", {lg_halt[0], lg_halt[1], lg_halt[11], lg_halt[12]}, 4'b0110);
        check("ld_done", {lg_done[11], lg_done[12], lg_done[13]}, 3'b010);
        check("ld_busy", {lg_busy[0], lg_busy[1], lg_busy[12], lg_busy[13]}, 4'b0110);
        check("ld_aw", {lg_aw[1], lg_aw[10], lg_aw[11]}, 3'b110);
        count_pulses(20);
        check("ld_bwr_cnt", n_bwr, 0);

        // Save of 4 bytes
        preload(32'h0, 32'hA0A1A2A3);
        run(22, -1, 0, -1, -1);
        exp_b = 32'hA0A1A2A3;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("sv_bwr%0d", k), lg_bwr[5+3*k], 1);
            check($sformatf("sv_baddr%0d", k), lg_baddr[5+3*k], k);
            check($sformatf("sv_bdata%0d", k), lg_bdata[5+3*k], exp_b[31-8*k -: 8]);
            check($sformatf("sv_buf%0d", k), bmem[k], exp_b[31-8*k -: 8]);
        end
        check("sv_done", {lg_done[15], lg_done[16], lg_busy[16], lg_busy[17]}, 4'b0110);
        check("sv_aw", lg_aw[3], 0);
        count_pulses(22);
        check("sv_we_cnt", n_we, 0);
        check("sv_bwr_cnt", n_bwr, 4);
        check("sv_overlap", n_both, 0);

        // Simultaneous starts: load wins
        preload(32'h05060708, 32'hF0F1F2F3);
        run(22, 0, 0, -1, -1);
        count_pulses(22);
        check("both_done_cnt", n_done, 1);
        check("both_done_at", lg_done[12], 1);
        check("both_bwr_cnt", n_bwr, 0);
        check("both_ram", {ram[0], ram[1], ram[2], ram[3]}, 32'h05060708);
        check("both_buf", {bmem[0], bmem[1], bmem[2], bmem[3]}, 32'h05060708);

        // Save request during an active load is dropped
        preload(32'h31323334, 32'h0);
        run(22, 0, 5, -1, -1);
        count_pulses(22);
        check("ign_done_cnt", n_done, 1);
        check("ign_done_at", lg_done[12], 1);
        check("ign_bwr_cnt", n_bwr, 0);
        check("ign_ram", {ram[0], ram[1], ram[2], ram[3]}, 32'h31323334);

        // Reset while fetching byte 2 aborts, then a fresh load completes
        preload(32'h41424344, 32'h0);
        run(22, 0, -1, 7, -1);
        check("abort_out", {lg_halt[8], lg_busy[8], lg_we[8], lg_aw[8], lg_done[8]}, 0);
        check("abort_addr", {lg_addr[8], lg_baddr[8]}, 0);
        count_pulses(22);
        check("abort_done_cnt", n_done, 0);
        check("abort_ram", {ram[0], ram[1], ram[2], ram[3]}, 32'h41420000);
        run(22, 0, -1, -1, -1);
        count_pulses(22);
        check("fresh_done_cnt", n_done, 1);
        check("fresh_done_at", lg_done[12], 1);
        check("fresh_ram", {ram[0], ram[1], ram[2], ram[3]}, 32'h41424344);

        // Single-byte save with minimal settle
        run(12, -1, -1, -1, 0);
        n_bwr = 0; n_done = 0;
        for (int c = 0; c < 12; c++) begin
            n_bwr  += int'(lg_bwr2[c]);
            n_done += int'(lg_done2[c]);
        end
        check("one_bwr_cnt", n_bwr, 1);
        check("one_bwr_at", lg_bwr2[4], 1);
        check("one_baddr", lg_baddr2[4], 0);
        check("one_bdata", lg_bdata2[4], 8'h5A);
        check("one_done_at", {lg_done2[5], lg_done2[6], lg_done2[7]}, 3'b010);
        check("one_done_cnt", n_done, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
